// File: rtl/delay_pkg.sv
// Shared limits for the delay line and its embedded clock divider.
// Kept here so the legal parameter ranges are stated in one place.
package delay_pkg;

    localparam int DELAY_MIN = 1;
    localparam int DELAY_MAX = 64;
    localparam int DIV_MIN   = 1;
    localparam int DIV_MAX   = 256;

endpackage

// File: rtl/delay_clk_divider.sv
// Free-running 50% duty divider: div_out toggles every DIV_HALF clocks.
// Counter and output restart from zero on synchronous reset.
import delay_pkg::*;

module clk_divider #(
    parameter int DIV_HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic div_out
);

    localparam int CW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV_HALF - 1);

    logic [CW-1:0] r_cnt;
    logic          r_div;

    generate
        if (DIV_HALF < DIV_MIN || DIV_HALF > DIV_MAX) begin : g_bad_div
            $error("clk_divider: DIV_HALF out of range");
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_div <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
            r_div <= ~r_div;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign div_out = r_div;

endmodule

// File: rtl/delay.sv
// Fixed-latency strobe delay line with flush, plus an embedded
// clock divider producing a slow square-wave enable.
import delay_pkg::*;

module delay #(
    parameter int DELAY    = 8,
    parameter int DIV_HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic clr,
    output logic dout,
    output logic div_out
);

    logic [DELAY-1:0] r_sr;
    logic [DELAY-1:0] w_next;

    generate
        if (DELAY < DELAY_MIN || DELAY > DELAY_MAX) begin : g_bad_delay
            $error("delay: DELAY out of range");
        end
        // A one-stage line has no older bits to carry forward.
        if (DELAY == 1) begin : g_one
            assign w_next = din;
        end else begin : g_many
            assign w_next = {r_sr[DELAY-2:0], din};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (clr) begin
            r_sr <= '0;
        end else begin
            r_sr <= w_next;
        end
    end

    assign dout = r_sr[DELAY-1];

    clk_divider #(
        .DIV_HALF (DIV_HALF)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_out (div_out)
    );

endmodule

// File: tb/tb_delay.sv
// Directed bench for delay: two instances (8/2 and 1/1) checked each
// cycle against a queue scoreboard and a closed-form divider model.
module tb_delay;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;
    logic clr = 1'b0;
    logic dout_a, div_a;
    logic dout_b, div_b;

    int checks = 0;
    int errors = 0;
    int n_edges = 0;

    logic q_a[$];
    logic q_b[$];

    always #5 clk = ~clk;

    delay #(.DELAY(8), .DIV_HALF(2)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .clr     (clr),
        .dout    (dout_a),
        .div_out (div_a)
    );

    delay #(.DELAY(1), .DIV_HALF(1)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .clr     (clr),
        .dout    (dout_b),
        .div_out (div_b)
    );

    function automatic logic div_exp(input int n, input int half);
        return logic'((n / half) % 2);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b (edge %0d)", tag, obs, exp, n_edges);
        end
    endtask

    task automatic flush_q();
        q_a = {};
        q_b = {};
        repeat (8) q_a.push_back(1'b0);
        q_b.push_back(1'b0);
    endtask

    task automatic step(input logic d, input logic c, input logic r);
        @(negedge clk);
        din = d;
        clr = c;
        rst_n = r;
        @(posedge clk);
        if (!r) begin
            flush_q();
            n_edges = 0;
        end else begin
            if (c) begin
                flush_q();
            end else begin
                void'(q_a.pop_front());
                q_a.push_back(d);
                void'(q_b.pop_front());
                q_b.push_back(d);
            end
            n_edges++;
        end
        #1;
        chk("dout_d8", dout_a, q_a[0]);
        chk("div_h2", div_a, div_exp(n_edges, 2));
        chk("dout_d1", dout_b, q_b[0]);
        chk("div_h1", div_b, div_exp(n_edges, 1));
    endtask

    initial begin
        flush_q();
        // Reset held with din high: nothing may leak through.
        repeat (3) step(1'b1, 1'b0, 1'b0);

        // Single pulse then a long quiet stretch.
        repeat (4) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        repeat (45) step(1'b0, 1'b0, 1'b1);

        // Pulse train 1,1,0,1.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        repeat (12) step(1'b0, 1'b0, 1'b1);

        // Flush with din high on the clr edge, then a normal pulse.
        step(1'b1, 1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0, 1'b1);

        // Reset while a pulse is in flight and div_out is high.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 8 && div_exp(n_edges, 2) == 1'b0; k++)
            step(1'b0, 1'b0, 1'b1);
        chk("div_high_before_rst", div_a, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b1);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 60; i++)
            step(logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 9) == 0), 1'b1);
        repeat (10) step(1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
